// File: rtl/winograd_pkg.sv
// Shared constants, FSM state encoding and tile-count helper for the Winograd
// F(2x2,3x3) feature-map scheduler.
package winograd_pkg;

  localparam int TILE   = 4;
  localparam int STRIDE = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  function automatic int tiles_per_dim(input int n);
    return (n - 2) / STRIDE;
  endfunction

endpackage

// File: rtl/tile_out_fifo.sv
// Two-entry output FIFO carrying a tile element plus its tile/frame tags.
module tile_out_fifo #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_tile_last,
  input  logic              push_frame_last,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              head_tile_last,
  output logic              head_frame_last,
  output logic              valid,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] data_reg [2];
  logic [1:0]        tags_reg [2];
  logic              wr_ptr_reg;
  logic              rd_ptr_reg;
  logic [1:0]        count_reg;
  logic              do_pop;

  assign do_pop = pop && (count_reg != 2'd0);

  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_reg[gi] <= '0;
        tags_reg[gi] <= '0;
      end else if (push && (wr_ptr_reg == 1'(gi))) begin
        data_reg[gi] <= push_data;
        tags_reg[gi] <= {push_tile_last, push_frame_last};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push)   wr_ptr_reg <= ~wr_ptr_reg;
      if (do_pop) rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + {1'b0, push} - {1'b0, do_pop};
    end
  end

  // The upstream read credit must make an overflowing push impossible.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && (count_reg == 2'd2)));

  assign valid           = (count_reg != 2'd0);
  assign count           = count_reg;
  assign head_data       = data_reg[rd_ptr_reg];
  assign head_tile_last  = valid && tags_reg[rd_ptr_reg][1];
  assign head_frame_last = valid && tags_reg[rd_ptr_reg][0];

endmodule

// File: rtl/winograd_tile_scheduler.sv
// Loads one frame into the feature-map RAM, then replays it as overlapping
// 4x4 stride-2 tiles toward the Winograd input transform.
module winograd_tile_scheduler
  import winograd_pkg::*;
#(
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_start,
  input  logic [DATA_W-1:0] io_in_data,
  input  logic              io_in_valid,
  output logic              io_in_ready,
  output logic [DATA_W-1:0] io_out_data,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic              io_out_tile_last,
  output logic              io_out_frame_last,
  output logic              io_busy,
  output logic              io_done,
  output logic [ADDR_W-1:0] io_ram_in_addr,
  output logic [DATA_W-1:0] io_ram_dataIn,
  output logic              io_ram_input_valid,
  output logic [ADDR_W-1:0] io_ram_output_addr,
  output logic              io_ram_output_valid,
  input  logic [DATA_W-1:0] io_ram_dataOut
);

  localparam int AW = ADDR_W + 2;
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [ADDR_W-1:0] TR_LAST  = ADDR_W'(tiles_per_dim(IMG_H) - 1);
  localparam logic [ADDR_W-1:0] TC_LAST  = ADDR_W'(tiles_per_dim(IMG_W) - 1);
  localparam logic [1:0]        RC_LAST  = 2'(TILE - 1);

  if ((IMG_W * IMG_H > 960) || (IMG_W * IMG_H > (1 << ADDR_W))) begin : g_bad_size
    $error("winograd_tile_scheduler: frame does not fit the feature-map RAM");
  end
  if ((IMG_W < 4) || (IMG_H < 4) || (IMG_W % 2 != 0) || (IMG_H % 2 != 0)) begin : g_bad_dims
    $error("winograd_tile_scheduler: frame dimensions must be even and >= 4");
  end

  state_e            state_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [ADDR_W-1:0] tr_reg, tc_reg;
  logic [1:0]        r_reg, c_reg;
  logic              inflight_reg, inflight_tile_last_reg, inflight_frame_last_reg;

  logic              wr_en, last_write, rd_en, pop, drain_done;
  logic              tile_last_rd, frame_last_rd;
  logic              fifo_valid;
  logic [1:0]        fifo_count;
  logic [2:0]        credit_used;
  logic [AW-1:0]     row_full, col_full, rd_addr_full;

  assign io_in_ready = (state_reg == LOAD);
  assign wr_en       = io_in_valid && io_in_ready;
  assign last_write  = wr_en && (wr_addr_reg == PIX_LAST);

  assign row_full     = (AW'(tr_reg) << 1) + AW'(r_reg);
  assign col_full     = (AW'(tc_reg) << 1) + AW'(c_reg);
  assign rd_addr_full = row_full * AW'(IMG_W) + col_full;

  assign tile_last_rd  = (r_reg == RC_LAST) && (c_reg == RC_LAST);
  assign frame_last_rd = tile_last_rd && (tr_reg == TR_LAST) && (tc_reg == TC_LAST);

  // A same-cycle pop frees its slot, so the credit sustains one read per cycle.
  assign pop         = fifo_valid && io_out_ready;
  assign credit_used = {1'b0, fifo_count} + {2'b0, inflight_reg} - {2'b0, pop};
  assign rd_en       = (state_reg == READ) && (credit_used < 3'd2);
  assign drain_done  = (state_reg == DRAIN) && (fifo_count == 2'd0) && !inflight_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg               <= IDLE;
      wr_addr_reg             <= '0;
      tr_reg                  <= '0;
      tc_reg                  <= '0;
      r_reg                   <= '0;
      c_reg                   <= '0;
      inflight_reg            <= 1'b0;
      inflight_tile_last_reg  <= 1'b0;
      inflight_frame_last_reg <= 1'b0;
    end else begin
      inflight_reg            <= rd_en;
      inflight_tile_last_reg  <= tile_last_rd;
      inflight_frame_last_reg <= frame_last_rd;
      case (state_reg)
        IDLE: begin
          if (io_start) begin
            state_reg   <= LOAD;
            wr_addr_reg <= '0;
            tr_reg      <= '0;
            tc_reg      <= '0;
            r_reg       <= '0;
            c_reg       <= '0;
          end
        end
        LOAD: begin
          if (wr_en) begin
            wr_addr_reg <= wr_addr_reg + ADDR_ONE;
            if (last_write) state_reg <= READ;
          end
        end
        READ: begin
          if (rd_en) begin
            // Two-bit r/c wrap naturally from 3 back to 0.
            c_reg <= c_reg + 2'd1;
            if (c_reg == RC_LAST) begin
              r_reg <= r_reg + 2'd1;
              if (r_reg == RC_LAST) begin
                if (tc_reg == TC_LAST) begin
                  tc_reg <= '0;
                  tr_reg <= (tr_reg == TR_LAST) ? '0 : tr_reg + ADDR_ONE;
                end else begin
                  tc_reg <= tc_reg + ADDR_ONE;
                end
              end
            end
            if (frame_last_rd) state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_done) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  tile_out_fifo #(.DATA_W(DATA_W)) u_fifo (
    .clk             (clock),
    .rst_n           (reset),
    .push            (inflight_reg),
    .push_data       (io_ram_dataOut),
    .push_tile_last  (inflight_tile_last_reg),
    .push_frame_last (inflight_frame_last_reg),
    .pop             (pop),
    .head_data       (io_out_data),
    .head_tile_last  (io_out_tile_last),
    .head_frame_last (io_out_frame_last),
    .valid           (fifo_valid),
    .count           (fifo_count)
  );

  assign io_out_valid        = fifo_valid;
  assign io_busy             = (state_reg != IDLE);
  assign io_done             = drain_done;
  assign io_ram_input_valid  = wr_en;
  assign io_ram_in_addr      = wr_addr_reg;
  assign io_ram_dataIn       = wr_en ? io_in_data : '0;
  assign io_ram_output_valid = rd_en;
  assign io_ram_output_addr  = rd_addr_full[ADDR_W-1:0];

endmodule

// File: tb/tb_winograd_tile_scheduler.sv
// Scoreboard bench for winograd_tile_scheduler on a 6x6 frame with a
// behavioural dual-port RAM attached.
module tb_winograd_tile_scheduler;

  localparam int W     = 6;
  localparam int H     = 6;
  localparam int N     = W * H;
  localparam int TPD_W = (W - 2) / 2;
  localparam int TPD_H = (H - 2) / 2;
  localparam int TOTAL = 16 * TPD_W * TPD_H;

  typedef struct packed {
    logic [15:0] data;
    logic        tl;
    logic        fl;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_start = 1'b0;
  logic [15:0] io_in_data = '0;
  logic        io_in_valid = 1'b0;
  logic        io_in_ready;
  logic [15:0] io_out_data;
  logic        io_out_valid;
  logic        io_out_ready = 1'b0;
  logic        io_out_tile_last;
  logic        io_out_frame_last;
  logic        io_busy;
  logic        io_done;
  logic [9:0]  io_ram_in_addr;
  logic [15:0] io_ram_dataIn;
  logic        io_ram_input_valid;
  logic [9:0]  io_ram_output_addr;
  logic        io_ram_output_valid;
  logic [15:0] io_ram_dataOut;

  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];
  logic [15:0] pix [N];
  logic [15:0] ram [1024];

  int wr_expect = 0;
  int pops_frame = 0;
  int issues_cnt = 0;
  int tl_cnt = 0;
  int done_cnt = 0;
  int cyc_ctr = 0;
  int first_pop_cyc = -1;
  int last_pop_cyc = -1;
  logic        hold_valid = 1'b0;
  logic [15:0] hold_data = '0;
  logic [1:0]  hold_tags = '0;

  winograd_tile_scheduler #(.IMG_W(W), .IMG_H(H), .DATA_W(16), .ADDR_W(10)) dut (
    .clock               (clock),
    .reset               (reset),
    .io_start            (io_start),
    .io_in_data          (io_in_data),
    .io_in_valid         (io_in_valid),
    .io_in_ready         (io_in_ready),
    .io_out_data         (io_out_data),
    .io_out_valid        (io_out_valid),
    .io_out_ready        (io_out_ready),
    .io_out_tile_last    (io_out_tile_last),
    .io_out_frame_last   (io_out_frame_last),
    .io_busy             (io_busy),
    .io_done             (io_done),
    .io_ram_in_addr      (io_ram_in_addr),
    .io_ram_dataIn       (io_ram_dataIn),
    .io_ram_input_valid  (io_ram_input_valid),
    .io_ram_output_addr  (io_ram_output_addr),
    .io_ram_output_valid (io_ram_output_valid),
    .io_ram_dataOut      (io_ram_dataOut)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (io_ram_input_valid) ram[io_ram_in_addr] <= io_ram_dataIn;
    if (io_ram_output_valid) io_ram_dataOut <= ram[io_ram_output_addr];
  end

  always @(posedge clock) cyc_ctr = cyc_ctr + 1;

  always @(negedge clock) begin : monitor
    exp_t e;
    if (!reset) begin
      hold_valid = 1'b0;
    end else begin
      if (io_ram_input_valid) begin
        checks++;
        assert (io_ram_in_addr === 10'(wr_expect)) else begin
          failures++;
          $error("FAIL wr_addr got=%0d exp=%0d", io_ram_in_addr, wr_expect);
        end
        wr_expect++;
      end
      if (io_ram_input_valid || io_ram_output_valid) begin
        checks++;
        assert (!(io_ram_input_valid && io_ram_output_valid)) else begin
          failures++;
          $error("FAIL port_overlap got=1 exp=0");
        end
      end
      if (hold_valid) begin
        checks++;
        assert ({io_out_valid, io_out_data, io_out_tile_last, io_out_frame_last} ===
                {1'b1, hold_data, hold_tags}) else begin
          failures++;
          $error("FAIL stall_hold got=%0d/%h exp=1/%h", io_out_valid, io_out_data, hold_data);
        end
      end
      if (io_ram_output_valid) issues_cnt++;
      if (io_out_valid && io_out_ready) begin
        checks++;
        assert (exp_q.size() > 0) else begin
          failures++;
          $error("FAIL unexpected_output got=%h exp=none", io_out_data);
        end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          checks++;
          assert ({io_out_data, io_out_tile_last, io_out_frame_last} === {e.data, e.tl, e.fl}) else begin
            failures++;
            $error("FAIL out_elem#%0d got=%h/%0d/%0d exp=%h/%0d/%0d", pops_frame,
                   io_out_data, io_out_tile_last, io_out_frame_last, e.data, e.tl, e.fl);
          end
        end
        if (first_pop_cyc < 0) first_pop_cyc = cyc_ctr;
        last_pop_cyc = cyc_ctr;
        pops_frame++;
        if (io_out_tile_last) tl_cnt++;
      end
      if (io_ram_output_valid || io_out_valid) begin
        checks++;
        assert (issues_cnt - pops_frame <= 2) else begin
          failures++;
          $error("FAIL read_ahead got=%0d exp<=2", issues_cnt - pops_frame);
        end
      end
      if (io_done) done_cnt++;
      hold_valid = io_out_valid && !io_out_ready;
      hold_data  = io_out_data;
      hold_tags  = {io_out_tile_last, io_out_frame_last};
    end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    assert ({io_in_ready, io_out_valid, io_out_tile_last, io_out_frame_last, io_busy,
             io_done, io_ram_input_valid, io_ram_output_valid} === 8'h00) else begin
      failures++;
      $error("FAIL %s_ctrl got=%b exp=00000000", tag,
             {io_in_ready, io_out_valid, io_out_tile_last, io_out_frame_last, io_busy,
              io_done, io_ram_input_valid, io_ram_output_valid});
    end
    checks++;
    assert ({io_out_data, io_ram_in_addr, io_ram_dataIn, io_ram_output_addr} === 52'd0) else begin
      failures++;
      $error("FAIL %s_bus got=%h exp=0", tag,
             {io_out_data, io_ram_in_addr, io_ram_dataIn, io_ram_output_addr});
    end
  endtask

  // Builds the frame, queues the expected tile stream and pulses start.
  task automatic start_frame(input int mul, input int add);
    exp_t e;
    for (int i = 0; i < N; i++) pix[i] = 16'(i * mul + add);
    exp_q.delete();
    for (int tr = 0; tr < TPD_H; tr++)
      for (int tc = 0; tc < TPD_W; tc++)
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) begin
            e.data = pix[(2 * tr + r) * W + 2 * tc + c];
            e.tl   = (r == 3) && (c == 3);
            e.fl   = e.tl && (tr == TPD_H - 1) && (tc == TPD_W - 1);
            exp_q.push_back(e);
          end
    wr_expect = 0;
    pops_frame = 0;
    issues_cnt = 0;
    tl_cnt = 0;
    done_cnt = 0;
    first_pop_cyc = -1;
    last_pop_cyc = -1;
    io_start = 1'b1;
    @(posedge clock); #1;
    io_start = 1'b0;
  endtask

  task automatic load_frame(input bit gaps);
    int  i = 0;
    int  guard = 0;
    bit  acc;
    while (i < N && guard < 2000) begin
      io_in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      io_in_data  = pix[i];
      acc = io_in_valid && io_in_ready;
      @(posedge clock); #1;
      if (acc) i++;
      guard++;
    end
    io_in_valid = 1'b0;
    check_eq("load_accepted", i, N);
    check_eq("writes_total", wr_expect, N);
  endtask

  task automatic drain_frame(input bit stall, input bit stray_start);
    logic [3:0] pat = 4'b1001;
    int cyc = 0;
    while (io_busy && cyc < 3000) begin
      io_out_ready = stall ? pat[cyc % 4] : 1'b1;
      io_start = stray_start && (cyc == 3);
      @(posedge clock); #1;
      cyc++;
    end
    io_start = 1'b0;
    io_out_ready = 1'b1;
    check_eq("busy_after_done", int'(io_busy), 0);
    check_eq("out_count", pops_frame, TOTAL);
    check_eq("queue_left", exp_q.size(), 0);
    check_eq("done_pulses", done_cnt, 1);
    check_eq("tile_last_count", tl_cnt, TPD_W * TPD_H);
  endtask

  initial begin
    #2;
    check_reset_outputs("reset_state");
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;

    // Stray pixels while idle must not reach the RAM.
    repeat (3) begin
      io_in_valid = 1'b1;
      io_in_data  = 16'hdead;
      @(posedge clock); #1;
    end
    io_in_valid = 1'b0;
    check_eq("idle_writes", wr_expect, 0);
    check_eq("idle_busy", int'(io_busy), 0);

    // Frame A: pixel = index, full throughput, latency and contiguity.
    io_out_ready = 1'b1;
    start_frame(1, 0);
    check_eq("busy_in_load", int'(io_busy), 1);
    load_frame(1'b0);
    check_eq("in_ready_after_load", int'(io_in_ready), 0);
    @(negedge clock);
    check_eq("latency_c0", int'(io_out_valid), 0);
    @(negedge clock);
    check_eq("latency_c1", int'(io_out_valid), 0);
    @(negedge clock);
    check_eq("latency_c2", int'(io_out_valid), 1);
    @(posedge clock); #1;
    drain_frame(1'b0, 1'b0);
    check_eq("contiguous", last_pop_cyc - first_pop_cyc, TOTAL - 1);

    // Frame B: input gaps, 1,0,0,1 backpressure, stray start during READ.
    start_frame(3, 7);
    load_frame(1'b1);
    drain_frame(1'b1, 1'b1);

    // Frame C: abandoned by reset after ten outputs.
    start_frame(5, 1000);
    load_frame(1'b0);
    for (int g = 0; g < 200 && pops_frame < 10; g++) begin
      @(posedge clock); #1;
    end
    check_eq("pops_before_reset", pops_frame, 10);
    #1 reset = 1'b0;
    #1 check_reset_outputs("async_reset");
    exp_q.delete();
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    check_eq("idle_after_reset", int'(io_busy), 0);

    // Frame D: full frame after reset, no stale FIFO contents allowed.
    start_frame(1, 500);
    load_frame(1'b0);
    drain_frame(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
